// File: rtl/prog_loader.sv
// Program loader: takes a length-prefixed little-endian byte stream and writes
// 32-bit instruction words to memory. The core stays in reset until the image is complete.
module prog_loader #(
    parameter int ADDR_W = 10
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [7:0]  byte_i,
    input  logic        byte_valid_i,
    output logic        byte_ready_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wdata_o,
    output logic        core_rst_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o,
    output logic [2:0]  dbg_state_o
);

    // Handshake: a byte moves on a rising edge only when byte_valid_i and
    // byte_ready_o are both high; byte_ready_o depends on state alone.

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LEN   = 3'd1,
        S_DATA  = 3'd2,
        S_WRITE = 3'd3,
        S_DONE  = 3'd4,
        S_ERR   = 3'd5
    } state_t;

    localparam logic [32:0] CAPACITY = 33'(1) << ADDR_W;

    state_t            state_q, state_d;
    logic [1:0]        byte_cnt_q, byte_cnt_d;
    logic [31:0]       len_q, len_d;
    logic [31:0]       shift_q, shift_d;
    logic [ADDR_W:0]   word_cnt_q, word_cnt_d;
    logic [ADDR_W:0]   addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;

    logic              accept;
    logic [31:0]       len_next;
    logic [31:0]       word_next;
    logic [ADDR_W:0]   word_cnt_inc;

    assign accept       = byte_valid_i && byte_ready_o;
    assign len_next     = {byte_i, len_q[31:8]};
    assign word_next    = {byte_i, shift_q[31:8]};
    assign word_cnt_inc = word_cnt_q + 1'b1;

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= S_IDLE;
            byte_cnt_q <= '0;
            len_q      <= '0;
            shift_q    <= '0;
            word_cnt_q <= '0;
            addr_q     <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            byte_cnt_q <= byte_cnt_d;
            len_q      <= len_d;
            shift_q    <= shift_d;
            word_cnt_q <= word_cnt_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        byte_cnt_d = byte_cnt_q;
        len_d      = len_q;
        shift_d    = shift_q;
        word_cnt_d = word_cnt_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d    = S_LEN;
                    byte_cnt_d = '0;
                    len_d      = '0;
                    word_cnt_d = '0;
                end
            end

            S_LEN: begin
                if (accept) begin
                    len_d      = len_next;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        if (len_next == 32'd0) begin
                            state_d = S_DONE;
                        end else if ({1'b0, len_next} > CAPACITY) begin
                            state_d = S_ERR;
                        end else begin
                            state_d = S_DATA;
                        end
                    end
                end
            end

            S_DATA: begin
                if (accept) begin
                    shift_d    = word_next;
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        // Latch address and data so they hold after the write.
                        addr_d  = word_cnt_q;
                        wdata_d = word_next;
                        state_d = S_WRITE;
                    end
                end
            end

            S_WRITE: begin
                word_cnt_d = word_cnt_inc;
                if (32'(word_cnt_inc) == len_q) begin
                    state_d = S_DONE;
                end else begin
                    state_d = S_DATA;
                end
            end

            S_DONE, S_ERR: begin
                if (start_i) begin
                    state_d    = S_LEN;
                    byte_cnt_d = '0;
                    len_d      = '0;
                    shift_d    = '0;
                    word_cnt_d = '0;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign byte_ready_o = (state_q == S_LEN) || (state_q == S_DATA);
    // Gated by reset so a write landing on a reset edge is never captured.
    assign mem_we_o     = (state_q == S_WRITE) && rst_i;
    assign mem_addr_o   = 32'({addr_q, 2'b00});
    assign mem_wdata_o  = wdata_q;
    assign core_rst_o   = (state_q != S_DONE);
    assign busy_o       = (state_q == S_LEN) || (state_q == S_DATA) || (state_q == S_WRITE);
    assign done_o       = (state_q == S_DONE);
    assign err_o        = (state_q == S_ERR);
    assign dbg_state_o  = state_q;

endmodule

// File: tb/tb_prog_loader.sv
// Bench for prog_loader: a 1024-word and a 16-word loader share one byte stream;
// each has its own expected-write queue checked whenever mem_we_o fires.
module tb_prog_loader;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_n;
    logic       start;
    logic       valid;
    logic [7:0] din;

    logic        b_ready, b_we, b_crst, b_busy, b_done, b_err;
    logic [31:0] b_addr, b_data;
    logic [2:0]  b_state;
    logic        s_ready, s_we, s_crst, s_busy, s_done, s_err;
    logic [31:0] s_addr, s_data;
    logic [2:0]  s_state;

    prog_loader #(.ADDR_W(10)) u_big (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .byte_i(din), .byte_valid_i(valid),
        .byte_ready_o(b_ready), .mem_we_o(b_we), .mem_addr_o(b_addr), .mem_wdata_o(b_data),
        .core_rst_o(b_crst), .busy_o(b_busy), .done_o(b_done), .err_o(b_err),
        .dbg_state_o(b_state)
    );

    prog_loader #(.ADDR_W(4)) u_small (
        .clk_i(clk), .rst_i(rst_n), .start_i(start), .byte_i(din), .byte_valid_i(valid),
        .byte_ready_o(s_ready), .mem_we_o(s_we), .mem_addr_o(s_addr), .mem_wdata_o(s_data),
        .core_rst_o(s_crst), .busy_o(s_busy), .done_o(s_done), .err_o(s_err),
        .dbg_state_o(s_state)
    );

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;
    int prev_wr     = 0;
    int last_wr     = 0;
    int widx        = 0;

    logic [63:0] exp_big_q[$];
    logic [63:0] exp_small_q[$];
    logic [31:0] img[$];

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Write monitor: pops the expected {addr, data} for every strobe.
    always @(negedge clk) begin
        cyc++;
        if (b_we) begin
            prev_wr = last_wr;
            last_wr = cyc;
            if (exp_big_q.size() == 0) check("big_extra_write", 64'(b_we), 64'd0);
            else check("big_write", {b_addr, b_data}, exp_big_q.pop_front());
        end
        if (s_we) begin
            if (exp_small_q.size() == 0) check("small_extra_write", 64'(s_we), 64'd0);
            else check("small_write", {s_addr, s_data}, exp_small_q.pop_front());
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps);
        bit acc;
        int n;
        if (gaps && $urandom_range(0, 2) == 0) begin
            valid = 1'b0;
            repeat ($urandom_range(1, 3)) @(posedge clk);
            #1;
        end
        din   = b;
        valid = 1'b1;
        acc   = 1'b0;
        n     = 0;
        while (!acc && n < 200) begin
            @(negedge clk);
            acc = b_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) check("byte_timeout", 64'(acc), 64'd1);
    endtask

    task automatic send_header(input logic [31:0] len, input bit gaps);
        widx = 0;
        for (int i = 0; i < 4; i++) send_byte(len[8*i +: 8], gaps);
    endtask

    task automatic send_word(input logic [31:0] w, input logic [31:0] len, input bit gaps);
        logic [63:0] e;
        e = {32'(widx * 4), w};
        if (len <= 32'd1024) exp_big_q.push_back(e);
        if (len <= 32'd16) exp_small_q.push_back(e);
        widx++;
        for (int i = 0; i < 4; i++) send_byte(w[8*i +: 8], gaps);
    endtask

    task automatic send_image(input logic [31:0] len, input bit gaps);
        send_header(len, gaps);
        for (int i = 0; i < img.size(); i++) send_word(img[i], len, gaps);
        valid = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0;
        repeat (2) begin
            start = 1'($urandom_range(0, 1));
            valid = 1'($urandom_range(0, 1));
            din   = 8'($urandom_range(0, 255));
            tick();
        end
        check("rst_core_rst", 64'(b_crst), 64'd1);
        check("rst_ready", 64'(b_ready), 64'd0);
        check("rst_we", 64'(b_we), 64'd0);
        check("rst_flags", {61'd0, b_busy, b_done, b_err}, 64'd0);
        check("rst_addr_data", {b_addr, b_data}, 64'd0);
        check("rst_small_core_rst", 64'(s_crst), 64'd1);
        start = 1'b0;
        valid = 1'b0;
        din   = 8'd0;
        rst_n = 1'b1;
        tick();
        check("idle_ready", 64'(b_ready), 64'd0);

        // Normal two-word load with continuous valid.
        pulse_start();
        check("len_busy", 64'(b_busy), 64'd1);
        check("len_ready", 64'(b_ready), 64'd1);
        img = '{32'h12345678, 32'hDEADBEEF};
        send_image(32'd2, 1'b0);
        check("write_strobe", 64'(b_we), 64'd1);
        tick();
        check("normal_done", 64'(b_done), 64'd1);
        check("normal_core_rel", 64'(b_crst), 64'd0);
        check("small_normal_done", 64'(s_done), 64'd1);
        check("write_spacing", 64'(last_wr - prev_wr), 64'd5);

        // Empty image, then restart.
        pulse_start();
        img = '{};
        send_image(32'd0, 1'b0);
        check("empty_done", 64'(b_done), 64'd1);
        check("empty_core_rel", 64'(b_crst), 64'd0);
        pulse_start();
        check("restart_core_rst", 64'(b_crst), 64'd1);
        check("restart_ready", 64'(b_ready), 64'd1);

        // Exactly fills the small loader.
        img = '{};
        for (int i = 0; i < 16; i++) img.push_back($urandom());
        send_image(32'd16, 1'b0);
        tick();
        check("full_small_done", 64'(s_done), 64'd1);
        check("full_big_done", 64'(b_done), 64'd1);
        check("full_last_addr", 64'(s_addr), 64'h3C);

        // One word over capacity for the small loader only.
        pulse_start();
        img = '{};
        for (int i = 0; i < 17; i++) img.push_back($urandom());
        send_header(32'd17, 1'b0);
        check("over_err", 64'(s_err), 64'd1);
        check("over_core_rst", 64'(s_crst), 64'd1);
        check("over_ready", 64'(s_ready), 64'd0);
        check("over_big_busy", 64'(b_busy), 64'd1);
        for (int i = 0; i < 17; i++) send_word(img[i], 32'd17, 1'b0);
        valid = 1'b0;
        tick();
        check("over_big_done", 64'(b_done), 64'd1);
        check("over_err_held", 64'(s_err), 64'd1);
        pulse_start();
        check("err_recover_err", 64'(s_err), 64'd0);
        check("err_recover_busy", 64'(s_busy), 64'd1);

        // Same two words with random gaps; valid stays up across WRITE.
        img = '{32'h12345678, 32'hDEADBEEF};
        send_image(32'd2, 1'b1);
        tick();
        check("gap_done", 64'(b_done), 64'd1);
        check("gap_small_done", 64'(s_done), 64'd1);

        // Reset after the first write of a three-word image.
        pulse_start();
        img = '{32'hA5A5_0001, 32'h0BAD_F00D, 32'hC0DE_CAFE};
        send_header(32'd3, 1'b0);
        send_word(img[0], 32'd3, 1'b0);
        send_byte(8'h0D, 1'b0);
        valid = 1'b0;
        rst_n = 1'b0;
        repeat (2) tick();
        check("midrst_state", 64'(b_state), 64'd0);
        check("midrst_busy", 64'(b_busy), 64'd0);
        check("midrst_core_rst", 64'(b_crst), 64'd1);
        rst_n = 1'b1;
        repeat (3) tick();
        pulse_start();
        send_image(32'd3, 1'b1);
        tick();
        check("reload_done", 64'(b_done), 64'd1);

        repeat (3) tick();
        check("big_pending", 64'(exp_big_q.size()), 64'd0);
        check("small_pending", 64'(exp_small_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/prog_loader.md
# prog_loader

Program loader that writes instruction words into the instruction memory read by the processor core. It accepts a byte stream over a valid/ready handshake, with a 4-byte length header followed by that many 32-bit words. It assembles each word little-endian and issues one write per word at sequential byte addresses from 0. It holds the core in reset while loading and releases it once the image is complete.

## Interface

Parameters:
- ADDR_W, default 10: word-address width of the instruction memory; capacity is 2**ADDR_W words.

Ports:
- clk_i  input  1  clock.
- rst_i  input  1  reset; synchronous, active-low.
- start_i  input  1  begin a (re)load; sampled in IDLE, DONE and ERR only.
- byte_i  input  8  stream data byte.
- byte_valid_i  input  1  byte_i is valid.
- byte_ready_o  output  1  loader can accept a byte this cycle.
- mem_we_o  output  1  instruction-memory write strobe, one cycle per word.
- mem_addr_o  output  32  byte address of the write: word index × 4.
- mem_wdata_o  output  32  assembled instruction word.
- core_rst_o  output  1  active-high reset to the core; 1 whenever the state is not DONE.
- busy_o  output  1  1 in LEN, DATA and WRITE.
- done_o  output  1  1 in DONE.
- err_o  output  1  1 in ERR.

## Operation

- A byte is accepted on a rising clk_i edge when byte_valid_i=1 and byte_ready_o=1. Bytes presented while byte_ready_o=0 are not consumed; the sender holds them.

States:
- IDLE: byte_ready_o=0, core_rst_o=1. start_i=1 -> LEN.
- LEN: byte_ready_o=1. Collects 4 bytes into len[31:0], little-endian: the first byte lands in len[7:0]. The byte counter is 2 bits and wraps at 4. On the 4th accepted byte:
  - len==0 -> DONE.
  - len>2**ADDR_W -> ERR.
  - otherwise -> DATA.
- DATA: byte_ready_o=1. Collects 4 bytes into the word, little-endian. On the 4th accepted byte -> WRITE.
- WRITE: lasts exactly one cycle. byte_ready_o=0, mem_we_o=1, mem_addr_o={word_cnt,2'b00} zero-extended to 32 bits, mem_wdata_o=assembled word. Then word_cnt increments; word_cnt is ADDR_W+1 bits.
  - If the incremented word_cnt equals len -> DONE.
  - Otherwise -> DATA.
- DONE: core_rst_o=0, byte_ready_o=0. start_i=1 -> LEN; core_rst_o returns to 1 in that same next cycle, and word_cnt and len are cleared.
- ERR: core_rst_o=1, byte_ready_o=0. start_i=1 -> LEN; err_o clears and counters are cleared.
- start_i is ignored in LEN, DATA and WRITE.
- The loader never writes beyond word index len-1. The boundary case len==2**ADDR_W is legal and fills the memory exactly.

## Timing

- Reset (rst_i=0 at an edge): state IDLE, all counters and registers 0.
  - Outputs after reset: core_rst_o=1, all other outputs 0, mem_addr_o=0, mem_wdata_o=0.
  - Reset mid-load aborts with no further write. A write in progress in WRITE is suppressed if rst_i=0 on that edge.
- All outputs are registered-state decodes. No combinational path from byte_valid_i to byte_ready_o.
- Write latency: if the 4th byte of a word is accepted at edge N, mem_we_o is high for the cycle between edges N and N+1, and the memory captures the word at edge N+1.
- Throughput: with byte_valid_i held at 1, a word takes 5 cycles (4 byte cycles plus 1 WRITE cycle).
- Header: with len≠0 and in range, the first data byte can be accepted on the cycle after the 4th header byte.
- DONE or ERR is entered at the edge after the last WRITE cycle, or after the 4th header byte for len==0 or an out-of-range len.
- mem_addr_o and mem_wdata_o hold their last values outside WRITE; they are meaningful only while mem_we_o=1.

## Test plan

- Reset: drive rst_i=0 for 2 cycles with random inputs -> core_rst_o=1, byte_ready_o=0, mem_we_o=0, busy_o=done_o=err_o=0.
- Normal load (ADDR_W=10): pulse start_i, then stream 02 00 00 00 78 56 34 12 EF BE AD DE with continuous valid -> exactly two writes: addr 0x0/data 0x12345678 and addr 0x4/data 0xDEADBEEF, each one cycle wide and 5 cycles apart. done_o=1 and core_rst_o=0 on the following cycle.
- Empty image: header 00 00 00 00 -> no mem_we_o pulse; DONE the cycle after the 4th byte. Then pulse start_i -> core_rst_o=1 and byte_ready_o=1 on the next cycle.
- Capacity (ADDR_W=4): len=16 -> 16 writes ending at addr 0x3C, then DONE. len=17 (11 00 00 00) -> ERR, zero writes, core_rst_o=1; start_i then recovers to LEN with err_o=0.
- Backpressure and gaps: insert random byte_valid_i=0 cycles, and present byte_valid_i=1 during WRITE -> that byte is not consumed until the next DATA cycle; the written data is unchanged versus the gap-free run.
- Reset mid-load: reset after the first write of a 3-word image -> IDLE, no further writes. A fresh start_i plus the full image rewrites from addr 0x0.
